uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the single UART transmit stream and arbiter status.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [2:0]         grant_id;
    logic               busy;
    logic               abort;

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant_id, busy, abort
    );

    // Requesters and transmitter side.
    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant_id, busy, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter feeding N_REQ byte streams into one UART
// transmitter, with an idle gap after each message and a stall timeout.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int GAP_CLKS     = 235,
    parameter int TIMEOUT_CLKS = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus_io
);
    typedef enum logic [1:0] {IDLE, LOCK, GAP} state_e;

    localparam logic [15:0] GAP_LAST    = 16'(GAP_CLKS == 0 ? 0 : GAP_CLKS - 1);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CLKS);
    localparam logic [2:0]  LAST_RST    = 3'(N_REQ - 1);

    state_e      state_q;
    logic [2:0]  grant_q;
    logic [2:0]  last_grant_q;
    logic        busy_q;
    logic        abort_q;
    logic [15:0] gap_cnt_q;
    logic [15:0] stall_cnt_q;

    logic        sel_valid;
    logic        sel_last;
    logic [7:0]  sel_data;
    logic        any_req;
    logic [2:0]  rr_pick_d;
    logic        xfer;
    logic        stall_hit;
    logic        lock_end;
    logic [15:0] stall_inc;

    // Mux the granted requester onto the shared path.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                sel_valid = bus_io.req_valid[i];
                sel_last  = bus_io.req_last[i];
                sel_data  = bus_io.req_data[8*i +: 8];
            end
        end
    end

    // Lowest offset from last_grant+1 wins; scanning far-to-near lets it overwrite.
    always_comb begin
        any_req   = |bus_io.req_valid;
        rr_pick_d = last_grant_q;
        for (int off = N_REQ; off >= 1; off--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (i == (int'(last_grant_q) + off) % N_REQ && bus_io.req_valid[i]) begin
                    rr_pick_d = 3'(i);
                end
            end
        end
    end

    always_comb begin
        bus_io.tx_valid  = 1'b0;
        bus_io.tx_data   = 8'h00;
        bus_io.req_ready = '0;
        if (state_q == LOCK) begin
            bus_io.tx_valid = sel_valid;
            bus_io.tx_data  = sel_data;
            for (int i = 0; i < N_REQ; i++) begin
                bus_io.req_ready[i] = (grant_q == 3'(i)) && bus_io.tx_ready;
            end
        end
    end

    assign xfer      = (state_q == LOCK) && sel_valid && bus_io.tx_ready;
    assign stall_inc = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
    assign stall_hit = (state_q == LOCK) && !sel_valid && (stall_inc >= TIMEOUT_LIM);
    assign lock_end  = (xfer && sel_last) || stall_hit;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 3'd0;
            last_grant_q <= LAST_RST;
            busy_q       <= 1'b0;
            abort_q      <= 1'b0;
            gap_cnt_q    <= 16'd0;
            stall_cnt_q  <= 16'd0;
        end else begin
            abort_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q     <= LOCK;
                        grant_q     <= rr_pick_d;
                        busy_q      <= 1'b1;
                        stall_cnt_q <= 16'd0;
                    end
                end
                LOCK: begin
                    if (lock_end) begin
                        last_grant_q <= grant_q;
                        abort_q      <= stall_hit;
                        stall_cnt_q  <= 16'd0;
                        gap_cnt_q    <= 16'd0;
                        if (GAP_CLKS == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= GAP;
                        end
                    end else if (sel_valid) begin
                        stall_cnt_q <= 16'd0;
                    end else begin
                        stall_cnt_q <= stall_inc;
                    end
                end
                GAP: begin
                    if (gap_cnt_q >= GAP_LAST) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        gap_cnt_q <= 16'd0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.grant_id = grant_q;
    assign bus_io.busy     = busy_q;
    assign bus_io.abort    = abort_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: three arbiter configurations (default, short timeout, no gap)
// driven through their interfaces with hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    logic clk;
    logic rst_n;

    uart_tx_arbiter_if #(.N_REQ(4)) a_if ();
    uart_tx_arbiter_if #(.N_REQ(4)) b_if ();
    uart_tx_arbiter_if #(.N_REQ(4)) c_if ();

    uart_tx_arbiter #(.N_REQ(4), .GAP_CLKS(235), .TIMEOUT_CLKS(65535)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus_io(a_if)
    );
    uart_tx_arbiter #(.N_REQ(4), .GAP_CLKS(235), .TIMEOUT_CLKS(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus_io(b_if)
    );
    uart_tx_arbiter #(.N_REQ(4), .GAP_CLKS(0), .TIMEOUT_CLKS(65535)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus_io(c_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_if.req_valid = '0; a_if.req_data = '0; a_if.req_last = '0; a_if.tx_ready = 1'b0;
        b_if.req_valid = '0; b_if.req_data = '0; b_if.req_last = '0; b_if.tx_ready = 1'b0;
        c_if.req_valid = '0; c_if.req_data = '0; c_if.req_last = '0; c_if.tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    int         n_xfer;
    int         last_k;
    int         gap_n;
    int         ab_k;
    int         regrant_k;
    int         idx;
    bit         quiet;
    bit         rdy_ok;
    logic [7:0] got_q[$];
    int         exp_s2_grant[4] = '{0, 1, 3, 0};
    int         exp_s2_data[4]  = '{'hA0, 'hA1, 'hA3, 'hA0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset holds everything quiet even with a request pending.
        clear_inputs();
        rst_n = 1'b0;
        a_if.req_valid = 4'b0001;
        a_if.tx_ready  = 1'b1;
        cyc();
        cyc();
        #1;
        check("rst_busy",   a_if.busy,      0);
        check("rst_grant",  a_if.grant_id,  0);
        check("rst_txv",    a_if.tx_valid,  0);
        check("rst_txd",    a_if.tx_data,   0);
        check("rst_rdy",    a_if.req_ready, 0);
        check("rst_abort",  a_if.abort,     0);
        clear_inputs();
        rst_n = 1'b1;

        // Single requester, three bytes, then a 235-cycle gap.
        cyc();
        a_if.req_valid = 4'b0100;
        a_if.req_data  = {8'h00, 8'h44, 8'h00, 8'h00};
        a_if.tx_ready  = 1'b1;
        #1;
        check("s1_idle_txv",  a_if.tx_valid, 0);
        check("s1_idle_busy", a_if.busy,     0);
        cyc(); #1;
        check("s1_grant", a_if.grant_id,  2);
        check("s1_busy",  a_if.busy,      1);
        check("s1_txv0",  a_if.tx_valid,  1);
        check("s1_b0",    a_if.tx_data,   8'h44);
        check("s1_rdy",   a_if.req_ready, 4'b0100);
        cyc();
        a_if.req_data[23:16] = 8'h41;
        #1;
        check("s1_txv1", a_if.tx_valid, 1);
        check("s1_b1",   a_if.tx_data,  8'h41);
        cyc();
        a_if.req_data[23:16] = 8'h0A;
        a_if.req_last        = 4'b0100;
        #1;
        check("s1_txv2", a_if.tx_valid, 1);
        check("s1_b2",   a_if.tx_data,  8'h0A);
        cyc();
        a_if.req_valid = '0;
        a_if.req_last  = '0;
        #1;
        gap_n = 0;
        quiet = 1'b1;
        for (int k = 0; k < 400 && a_if.busy; k++) begin
            if (a_if.tx_valid || a_if.req_ready != 4'b0000) quiet = 1'b0;
            gap_n++;
            cyc(); #1;
        end
        check("s1_gap_len",   gap_n, 235);
        check("s1_gap_quiet", quiet, 1);

        // Contention between 0, 1 and 3 with one-byte messages.
        do_reset();
        cyc();
        a_if.req_valid = 4'b1011;
        a_if.req_last  = 4'b1111;
        a_if.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        a_if.tx_ready  = 1'b1;
        #1;
        n_xfer = 0;
        last_k = 0;
        for (int k = 0; k < 1200 && n_xfer < 4; k++) begin
            if (a_if.tx_valid && a_if.tx_ready) begin
                check($sformatf("s2_grant%0d", n_xfer), a_if.grant_id, exp_s2_grant[n_xfer]);
                check($sformatf("s2_data%0d", n_xfer),  a_if.tx_data,  exp_s2_data[n_xfer]);
                check($sformatf("s2_rdy%0d", n_xfer),   a_if.req_ready,
                      32'(1) << exp_s2_grant[n_xfer]);
                if (n_xfer > 0) check($sformatf("s2_space%0d", n_xfer), k - last_k, 237);
                last_k = k;
                n_xfer++;
            end
            cyc(); #1;
        end
        check("s2_count", n_xfer, 4);

        // Back-pressure: tx_ready high one cycle in three, req 3 waiting alongside.
        do_reset();
        cyc();
        a_if.req_valid = 4'b1010;
        a_if.req_last  = 4'b1000;
        idx    = 0;
        rdy_ok = 1'b1;
        got_q.delete();
        for (int k = 0; k < 60 && got_q.size() < 4; k++) begin
            a_if.tx_ready        = (k % 3 == 2);
            a_if.req_data[15:8]  = 8'h10 + 8'(idx);
            a_if.req_last[1]     = (idx == 3);
            #1;
            if (a_if.busy && a_if.req_ready != {2'b00, a_if.tx_ready, 1'b0}) rdy_ok = 1'b0;
            if (a_if.tx_valid && a_if.tx_ready) begin
                got_q.push_back(a_if.tx_data);
                idx++;
            end
            cyc();
        end
        a_if.req_valid = '0;
        check("s3_count",  got_q.size(), 4);
        check("s3_rdy_ok", rdy_ok,       1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s3_byte%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx, 8'h10 + 8'(i));
        end

        // Timeout on a short-timeout instance; req 2 takes over after the gap.
        do_reset();
        cyc();
        b_if.req_valid = 4'b0110;
        b_if.req_data  = {8'h00, 8'h66, 8'h55, 8'h00};
        b_if.req_last  = 4'b0100;
        b_if.tx_ready  = 1'b1;
        #1;
        cyc(); #1;
        check("s4_grant", b_if.grant_id, 1);
        check("s4_txd",   b_if.tx_data,  8'h55);
        check("s4_txv",   b_if.tx_valid, 1);
        cyc();
        b_if.req_valid[1] = 1'b0;
        #1;
        ab_k = -1;
        for (int k = 0; k < 40; k++) begin
            if (b_if.abort) begin
                ab_k = k;
                break;
            end
            cyc(); #1;
        end
        check("s4_abort_at",   ab_k,        10);
        check("s4_abort_busy", b_if.busy,   1);
        check("s4_abort_txv",  b_if.tx_valid, 0);
        cyc(); #1;
        check("s4_abort_pulse", b_if.abort, 0);
        regrant_k = -1;
        for (int k = 0; k < 400; k++) begin
            if (b_if.tx_valid && b_if.tx_ready) begin
                regrant_k = k;
                break;
            end
            cyc(); #1;
        end
        check("s4_regrant_delay", regrant_k,     235);
        check("s4_regrant_id",    b_if.grant_id, 2);
        check("s4_regrant_data",  b_if.tx_data,  8'h66);

        // A request pulse that drops before any edge must not lock.
        do_reset();
        cyc();
        a_if.req_valid = 4'b0010;
        #1;
        a_if.req_valid = '0;
        cyc(); #1;
        check("s5_glitch_busy", a_if.busy, 0);

        // Reset during byte 2 of 5 from req 2, then req 0 wins first.
        cyc();
        a_if.req_valid = 4'b0100;
        a_if.req_data  = {8'h00, 8'h01, 8'h00, 8'h00};
        a_if.tx_ready  = 1'b1;
        #1;
        cyc(); #1;
        check("s6_grant", a_if.grant_id, 2);
        check("s6_b1",    a_if.tx_data,  8'h01);
        cyc();
        a_if.req_data[23:16] = 8'h02;
        a_if.req_valid[0]    = 1'b1;
        a_if.req_data[7:0]   = 8'hE0;
        a_if.req_last[0]     = 1'b1;
        #1;
        check("s6_b2", a_if.tx_data, 8'h02);
        rst_n = 1'b0;
        #1;
        check("s6_rst_txv",   a_if.tx_valid,  0);
        check("s6_rst_txd",   a_if.tx_data,   0);
        check("s6_rst_rdy",   a_if.req_ready, 0);
        check("s6_rst_busy",  a_if.busy,      0);
        check("s6_rst_grant", a_if.grant_id,  0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        check("s6_rel_txv", a_if.tx_valid, 0);
        cyc(); #1;
        check("s6_post_grant", a_if.grant_id,  0);
        check("s6_post_data",  a_if.tx_data,   8'hE0);
        check("s6_post_rdy",   a_if.req_ready, 4'b0001);

        // No-gap instance: back-to-back one-byte messages from req 0.
        do_reset();
        cyc();
        c_if.req_valid = 4'b0001;
        c_if.req_data  = {24'h0, 8'hC1};
        c_if.req_last  = 4'b0001;
        c_if.tx_ready  = 1'b1;
        #1;
        check("s7_idle0_busy", c_if.busy, 0);
        cyc(); #1;
        check("s7_m0_txv",  c_if.tx_valid, 1);
        check("s7_m0_data", c_if.tx_data,  8'hC1);
        check("s7_m0_busy", c_if.busy,     1);
        cyc();
        c_if.req_data[7:0] = 8'hC2;
        #1;
        check("s7_idle1_busy", c_if.busy,     0);
        check("s7_idle1_txv",  c_if.tx_valid, 0);
        cyc(); #1;
        check("s7_m1_txv",   c_if.tx_valid, 1);
        check("s7_m1_data",  c_if.tx_data,  8'hC2);
        check("s7_m1_grant", c_if.grant_id, 0);
        cyc();
        c_if.req_valid = '0;
        #1;
        check("s7_end_busy", c_if.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
